mult_arbiter: RTL and testbench

- Shares one iterative multiplier core between two requesters (touch-screen input path and a test/sequencer path).
- Arbitrates requests round-robin and drives the core's level-held begin/end protocol.
- Routes the 64-bit product back to the owning requester.
- Aborts a hung multiplication after a timeout, and keeps per-requester completion counters for the LCD display.

---
 rtl/mult_arbiter_if.sv | 28 ++
 rtl/mult_arbiter.sv | 95 +++++++++
 tb/tb_mult_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - requester and multiplier-core signal bundle for mult_arbiter
interface mult_arbiter_if;
   logic [1:0]  req_valid;
   logic [63:0] req_op1;
   logic [63:0] req_op2;
   logic [1:0]  req_ready;
   logic [1:0]  resp_valid;
   logic [1:0]  resp_ready;
   logic [63:0] resp_product;
   logic        resp_err;
   logic        mul_begin;
   logic [31:0] mul_op1;
   logic [31:0] mul_op2;
   logic [63:0] mul_product;
   logic        mul_end;

   // Environment side: requesters plus the multiplier core
   modport master (
      output req_valid, req_op1, req_op2, resp_ready, mul_product, mul_end,
      input  req_ready, resp_valid, resp_product, resp_err, mul_begin, mul_op1, mul_op2
   );

   // Arbiter side
   modport slave (
      input  req_valid, req_op1, req_op2, resp_ready, mul_product, mul_end,
      output req_ready, resp_valid, resp_product, resp_err, mul_begin, mul_op1, mul_op2
   );
endinterface

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin sharing of one iterative multiplier between two requesters
module mult_arbiter #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             resetn,
   mult_arbiter_if.slave    bus,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt0,
   output logic [CNT_W-1:0] done_cnt1
);

   localparam int            TW     = $clog2(TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

   state_t        state;
   logic          last_grant;
   logic          owner;
   logic [TW-1:0] timer;
   logic          grant_idx;

   // Request acceptance: only in IDLE, ties go to whoever was not served last
   always_comb begin
      bus.req_ready = 2'b00;
      if (state == IDLE) begin
         bus.req_ready[0] = bus.req_valid[0] & (~bus.req_valid[1] | last_grant);
         bus.req_ready[1] = bus.req_valid[1] & (~bus.req_valid[0] | ~last_grant);
      end
      grant_idx = bus.req_ready[1];
   end

   assign busy = (state != IDLE);

   // Control FSM: accept, run the core with begin held high, hold the response until consumed
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state            <= IDLE;
         bus.mul_begin    <= 1'b0;
         bus.mul_op1      <= '0;
         bus.mul_op2      <= '0;
         bus.resp_valid   <= 2'b00;
         bus.resp_product <= '0;
         bus.resp_err     <= 1'b0;
         done_cnt0        <= '0;
         done_cnt1        <= '0;
         last_grant       <= 1'b1;
         owner            <= 1'b0;
         timer            <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|bus.req_ready) begin
                  bus.mul_op1   <= grant_idx ? bus.req_op1[63:32] : bus.req_op1[31:0];
                  bus.mul_op2   <= grant_idx ? bus.req_op2[63:32] : bus.req_op2[31:0];
                  owner         <= grant_idx;
                  last_grant    <= grant_idx;
                  timer         <= '0;
                  bus.mul_begin <= 1'b1;
                  state         <= RUN;
               end
            end
            RUN: begin
               timer <= timer + 1'b1;
               // A completion on the timeout cycle still counts as a real result
               if (bus.mul_end) begin
                  bus.resp_product <= bus.mul_product;
                  bus.resp_err     <= 1'b0;
                  bus.mul_begin    <= 1'b0;
                  bus.resp_valid   <= owner ? 2'b10 : 2'b01;
                  state            <= RESP;
               end else if (timer == T_LAST) begin
                  bus.resp_product <= '0;
                  bus.resp_err     <= 1'b1;
                  bus.mul_begin    <= 1'b0;
                  bus.resp_valid   <= owner ? 2'b10 : 2'b01;
                  state            <= RESP;
               end
            end
            RESP: begin
               if (bus.resp_ready[owner]) begin
                  bus.resp_valid <= 2'b00;
                  if (owner) done_cnt1 <= done_cnt1 + 1'b1;
                  else       done_cnt0 <= done_cnt0 + 1'b1;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed vector bench for mult_arbiter
module tb_mult_arbiter;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        busy;
   logic [15:0] done_cnt0;
   logic [15:0] done_cnt1;

   int checks = 0;
   int failures = 0;
   int core_lat = 1;
   int core_cnt = 0;

   mult_arbiter_if bus();

   mult_arbiter #(.TIMEOUT(64), .CNT_W(16)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (bus.slave),
      .busy      (busy),
      .done_cnt0 (done_cnt0),
      .done_cnt1 (done_cnt1)
   );

   always #5 clk = ~clk;

   // Core model: completes in core_lat begin-high cycles, never when core_lat is 0
   always @(posedge clk) begin
      if (!bus.mul_begin) core_cnt <= 0;
      else                core_cnt <= core_cnt + 1;
   end
   assign bus.mul_end     = bus.mul_begin && (core_lat != 0) && (core_cnt == core_lat - 1);
   assign bus.mul_product = bus.mul_begin ? ({32'd0, bus.mul_op1} * {32'd0, bus.mul_op2}) : 64'd0;

   typedef struct {
      bit          rst;
      logic [1:0]  v;
      logic [31:0] a0, b0, a1, b1;
      int          lat;
      logic [1:0]  g;
      logic [63:0] p;
      logic        e;
      int          nb;
      int          c0, c1;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn         = 1'b0;
      bus.req_valid  = 2'b00;
      bus.resp_ready = 2'b00;
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic do_op(input logic [1:0] v, input logic [31:0] a0, b0, a1, b1,
                        input int lat, input logic [1:0] g, input logic [63:0] p,
                        input logic e, input int nb, input int c0, input int c1);
      int n;
      int nbeg;
      core_lat    = lat;
      bus.req_valid = v;
      bus.req_op1 = {a1, a0};
      bus.req_op2 = {b1, b0};
      #1;
      n = 0;
      while (bus.req_ready == 2'b00 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      check("grant", {62'd0, bus.req_ready}, {62'd0, g});
      @(posedge clk); #1;
      bus.req_op1 = 64'hDEADBEEF_CAFEF00D;
      bus.req_op2 = 64'h0BADF00D_12345678;
      @(negedge clk);
      nbeg = 0;
      n = 0;
      while (bus.resp_valid == 2'b00 && n < 300) begin
         if (bus.mul_begin) nbeg++;
         @(negedge clk);
         n++;
      end
      check("begin_cycles", 64'(nbeg), 64'(nb));
      check("resp_valid", {62'd0, bus.resp_valid}, {62'd0, g});
      check("product", bus.resp_product, p);
      check("err", {63'd0, bus.resp_err}, {63'd0, e});
      check("begin_low_in_resp", {63'd0, bus.mul_begin}, 64'd0);
      bus.resp_ready = 2'b11;
      bus.req_valid  = 2'b00;
      @(posedge clk);
      @(negedge clk);
      bus.resp_ready = 2'b00;
      check("busy_after", {63'd0, busy}, 64'd0);
      check("resp_valid_clr", {62'd0, bus.resp_valid}, 64'd0);
      check("cnt0", {48'd0, done_cnt0}, 64'(c0));
      check("cnt1", {48'd0, done_cnt1}, 64'(c1));
   endtask

   initial begin
      int n;
      //          rst  v      a0            b0     a1            b1   lat g      product              e  nb  c0 c1
      tbl[0] = '{1'b1, 2'b11, 32'h10,       32'h10, 32'hFFFFFFFF, 32'h2, 5, 2'b01, 64'h100,             0, 5,  1, 0};
      tbl[1] = '{1'b0, 2'b11, 32'h10,       32'h10, 32'hFFFFFFFF, 32'h2, 7, 2'b10, 64'h1FFFFFFFE,       0, 7,  1, 1};
      tbl[2] = '{1'b0, 2'b11, 32'h10,       32'h10, 32'hFFFFFFFF, 32'h2, 3, 2'b01, 64'h100,             0, 3,  2, 1};
      tbl[3] = '{1'b0, 2'b11, 32'h10,       32'h10, 32'hFFFFFFFF, 32'h2, 10, 2'b10, 64'h1FFFFFFFE,      0, 10, 2, 2};
      tbl[4] = '{1'b1, 2'b01, 32'd3,        32'd5,  32'd0,        32'd0, 33, 2'b01, 64'd15,             0, 33, 1, 0};
      tbl[5] = '{1'b0, 2'b10, 32'd0,        32'd0,  32'd7,        32'd9, 0,  2'b10, 64'd0,              1, 64, 1, 1};
      tbl[6] = '{1'b0, 2'b01, 32'h12345678, 32'h10, 32'd0,        32'd0, 64, 2'b01, 64'h123456780,      0, 64, 2, 1};
      tbl[7] = '{1'b0, 2'b10, 32'd0,        32'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 2, 2'b10, 64'hFFFFFFFE00000001, 0, 2, 2, 2};

      bus.req_valid  = 2'b00;
      bus.req_op1    = '0;
      bus.req_op2    = '0;
      bus.resp_ready = 2'b00;

      do_reset();
      check("rst_begin", {63'd0, bus.mul_begin}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_resp_valid", {62'd0, bus.resp_valid}, 64'd0);
      check("rst_product", bus.resp_product, 64'd0);
      check("rst_err", {63'd0, bus.resp_err}, 64'd0);
      check("rst_op1", {32'd0, bus.mul_op1}, 64'd0);
      check("rst_cnt0", {48'd0, done_cnt0}, 64'd0);

      for (int i = 0; i < 8; i++) begin
         if (tbl[i].rst) do_reset();
         do_op(tbl[i].v, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1, tbl[i].lat,
               tbl[i].g, tbl[i].p, tbl[i].e, tbl[i].nb, tbl[i].c0, tbl[i].c1);
      end

      // Response stall with req1 waiting behind it
      core_lat      = 4;
      bus.req_valid = 2'b01;
      bus.req_op1   = {32'd0, 32'd6};
      bus.req_op2   = {32'd0, 32'd7};
      #1;
      check("stall_grant", {62'd0, bus.req_ready}, 64'd1);
      @(posedge clk); #1;
      n = 0;
      while (bus.resp_valid == 2'b00 && n < 50) begin
         @(negedge clk); n++;
      end
      bus.req_valid = 2'b10;
      bus.req_op1   = {32'd9, 32'd0};
      bus.req_op2   = {32'd11, 32'd0};
      for (int k = 0; k < 10; k++) begin
         #1;
         check("stall_resp_valid", {62'd0, bus.resp_valid}, 64'd1);
         check("stall_product", bus.resp_product, 64'd42);
         check("stall_req_ready", {62'd0, bus.req_ready}, 64'd0);
         @(negedge clk);
      end
      bus.resp_ready = 2'b01;
      #1;
      check("stall_ready_in_resp", {62'd0, bus.req_ready}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      bus.resp_ready = 2'b00;
      check("stall_cnt0", {48'd0, done_cnt0}, 64'd3);
      do_op(2'b10, 32'd0, 32'd0, 32'd9, 32'd11, 4, 2'b10, 64'd99, 1'b0, 4, 3, 3);

      // Reset in the middle of RUN
      core_lat      = 33;
      bus.req_valid = 2'b01;
      bus.req_op1   = {32'd0, 32'd2};
      bus.req_op2   = {32'd0, 32'd3};
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      repeat (5) @(negedge clk);
      check("midrun_begin", {63'd0, bus.mul_begin}, 64'd1);
      resetn = 1'b0;
      @(posedge clk); #1;
      check("midrst_begin", {63'd0, bus.mul_begin}, 64'd0);
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_resp_valid", {62'd0, bus.resp_valid}, 64'd0);
      check("midrst_cnt0", {48'd0, done_cnt0}, 64'd0);
      check("midrst_cnt1", {48'd0, done_cnt1}, 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      do_op(2'b01, 32'd4, 32'd5, 32'd0, 32'd0, 10, 2'b01, 64'd20, 1'b0, 10, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
